// File: rtl/regacc_pkg.sv
// Shared types and constants for the register-file access sequencer.
package regacc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        OUT     = 3'd3,
        WR      = 3'd4,
        WR_HOLD = 3'd5
    } state_t;

endpackage

// File: rtl/wb_buffer.sv
// One-entry writeback holding register; accepts when empty, freed by clear.
module wb_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    assign in_ready = !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for the 2-read/1-write register file: operand
// fetch with valid/ready return, buffered writeback, register 0 hard-wired.
module regfile_access_ctrl
    import regacc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ena,
    output logic              enb,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    output logic              enc,
    output logic [ADDR_W-1:0] addrc,
    output logic [DATA_W-1:0] datac
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic              rs_used_q;
    logic              rt_used_q;
    logic              rs_live;
    logic              rt_live;
    logic              issue_accept;

    logic              buf_full;
    logic              buf_clear;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    wb_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_buffer (
        .clk      (clk),
        .reset    (reset),
        .clear    (buf_clear),
        .in_valid (wb_valid),
        .in_ready (wb_ready),
        .in_addr  (wb_addr),
        .in_data  (wb_data),
        .full     (buf_full),
        .addr     (buf_addr),
        .data     (buf_data)
    );

    // A pending or arriving writeback blocks the issue so writes land first.
    assign issue_ready  = (state == IDLE) && !buf_full && !wb_valid && !reset;
    assign issue_accept = issue_valid && issue_ready;
    assign rs_live      = rs_used_q && (rs_q != ZERO_ADDR);
    assign rt_live      = rt_used_q && (rt_q != ZERO_ADDR);
    assign op_valid     = (state == OUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_used_q <= 1'b0;
            rt_used_q <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            state <= next_state;
            if (issue_accept) begin
                rs_q      <= rs;
                rt_q      <= rt;
                rs_used_q <= rs_used;
                rt_used_q <= rt_used;
            end
            if (state == RD_WAIT) begin
                op_a <= rs_live ? dataa : '0;
                op_b <= rt_live ? datab : '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        ena        = 1'b0;
        enb        = 1'b0;
        enc        = 1'b0;
        addra      = '0;
        addrb      = '0;
        addrc      = '0;
        datac      = '0;
        buf_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full || wb_valid) begin
                    next_state = WR;
                end else if (issue_valid) begin
                    next_state = RD;
                end
            end
            RD: begin
                ena        = rs_live;
                enb        = rt_live;
                addra      = rs_q;
                addrb      = rt_q;
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                addra      = rs_q;
                addrb      = rt_q;
                next_state = OUT;
            end
            OUT: begin
                if (op_ready) begin
                    next_state = IDLE;
                end
            end
            // Writes to register 0 still walk WR/WR_HOLD but never strobe.
            WR: begin
                enc        = (buf_addr != ZERO_ADDR);
                addrc      = buf_addr;
                datac      = buf_data;
                next_state = WR_HOLD;
            end
            WR_HOLD: begin
                addrc      = buf_addr;
                datac      = buf_data;
                buf_clear  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a small synchronous-read register file model.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ena;
    logic        enb;
    logic [4:0]  addra;
    logic [4:0]  addrb;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        enc;
    logic [4:0]  addrc;
    logic [31:0] datac;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem [32];
    logic [4:0]  enc_log [64];
    int          enc_cnt = 0;
    int          ena_cnt = 0;
    int          enb_cnt = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .rs          (rs),
        .rt          (rt),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ena         (ena),
        .enb         (enb),
        .addra       (addra),
        .addrb       (addrb),
        .dataa       (dataa),
        .datab       (datab),
        .enc         (enc),
        .addrc       (addrc),
        .datac       (datac)
    );

    // Register file: r0 holds garbage so any unsuppressed read of it shows up.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= {16'hC0DE, 16'(i)};
            mem[0] <= 32'hBAD0BAD0;
            dataa  <= 32'hA5A5A5A5;
            datab  <= 32'hA5A5A5A5;
        end else begin
            if (enc) mem[addrc] <= datac;
            if (ena) dataa <= mem[addra];
            if (enb) datab <= mem[addrb];
        end
        if (enc) begin
            enc_log[enc_cnt[5:0]] <= addrc;
            enc_cnt <= enc_cnt + 1;
        end
        if (ena) ena_cnt <= ena_cnt + 1;
        if (enb) enb_cnt <= enb_cnt + 1;
    end

    task automatic send_wb(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        #1;
        while (wb_ready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        vectors++;
        if (wb_ready !== 1'b1) begin
            $display("[TB] FAIL wb_accept_timeout: wb_ready=%b required 1", wb_ready);
            miscompares++;
        end
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic send_issue(input logic [4:0] s, input logic [4:0] t,
                              input logic su, input logic tu);
        int n = 0;
        issue_valid = 1'b1;
        rs = s; rt = t; rs_used = su; rt_used = tu;
        #1;
        while (issue_ready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        vectors++;
        if (issue_ready !== 1'b1) begin
            $display("[TB] FAIL issue_accept_timeout: issue_ready=%b required 1", issue_ready);
            miscompares++;
        end
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic wait_op_valid();
        int n = 0;
        #1;
        while (op_valid !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        vectors++;
        if (op_valid !== 1'b1) begin
            $display("[TB] FAIL op_valid_timeout: op_valid=%b required 1", op_valid);
            miscompares++;
        end
    endtask

    task automatic release_op();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue_valid = 1'b0; rs = '0; rt = '0; rs_used = 1'b0; rt_used = 1'b0;
        op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({issue_ready, op_valid, wb_ready} !== 3'b001) begin
            $display("[TB] FAIL reset_handshake: got %b required 001", {issue_ready, op_valid, wb_ready});
            miscompares++;
        end
        vectors++;
        if ({op_a, op_b} !== 64'h0) begin
            $display("[TB] FAIL reset_operands: got %h required 0", {op_a, op_b});
            miscompares++;
        end
        vectors++;
        if ({ena, enb, enc, addra, addrb, addrc, datac} !== 50'h0) begin
            $display("[TB] FAIL reset_strobes: got %h required 0", {ena, enb, enc, addra, addrb, addrc, datac});
            miscompares++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (issue_ready !== 1'b1) begin
            $display("[TB] FAIL post_reset_issue_ready: got %b required 1", issue_ready);
            miscompares++;
        end
    endtask

    task automatic test_wb_then_read();
        int c0, b0;
        @(negedge clk);
        c0 = enc_cnt;
        send_wb(5'd5, 32'hDEADBEEF);
        #1;
        vectors++;
        if ({enc, addrc, datac, wb_ready} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            $display("[TB] FAIL wr_cycle: got enc=%b addrc=%0d datac=%h wb_ready=%b required 1 5 deadbeef 0",
                     enc, addrc, datac, wb_ready);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({enc, addrc, datac, wb_ready} !== {1'b0, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            $display("[TB] FAIL wr_hold_cycle: got enc=%b addrc=%0d datac=%h wb_ready=%b required 0 5 deadbeef 0",
                     enc, addrc, datac, wb_ready);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({wb_ready, issue_ready} !== 2'b11 || enc_cnt - c0 != 1) begin
            $display("[TB] FAIL wr_done: got wb_ready=%b issue_ready=%b enc_pulses=%0d required 1 1 1",
                     wb_ready, issue_ready, enc_cnt - c0);
            miscompares++;
        end
        b0 = enb_cnt;
        send_issue(5'd5, 5'd0, 1'b1, 1'b1);
        #1;
        vectors++;
        if ({ena, addra, enb} !== {1'b1, 5'd5, 1'b0}) begin
            $display("[TB] FAIL rd_cycle: got ena=%b addra=%0d enb=%b required 1 5 0", ena, addra, enb);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({ena, addra, op_valid} !== {1'b0, 5'd5, 1'b0}) begin
            $display("[TB] FAIL rd_wait_cycle: got ena=%b addra=%0d op_valid=%b required 0 5 0", ena, addra, op_valid);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({op_valid, op_a, op_b} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
            $display("[TB] FAIL fetch_r5_r0: got v=%b a=%h b=%h required 1 deadbeef 0", op_valid, op_a, op_b);
            miscompares++;
        end
        vectors++;
        if (enb_cnt != b0) begin
            $display("[TB] FAIL rt_zero_strobe: got %0d enb pulses required 0", enb_cnt - b0);
            miscompares++;
        end
        release_op();
    endtask

    task automatic test_simultaneous();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        issue_valid = 1'b1; rs = 5'd3; rt = 5'd0; rs_used = 1'b1; rt_used = 1'b0;
        #1;
        vectors++;
        if ({issue_ready, wb_ready} !== 2'b01) begin
            $display("[TB] FAIL simul_ready: got issue_ready=%b wb_ready=%b required 0 1", issue_ready, wb_ready);
            miscompares++;
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        vectors++;
        if ({enc, addrc, datac, issue_ready} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
            $display("[TB] FAIL simul_write_first: got enc=%b addrc=%0d datac=%h issue_ready=%b required 1 3 11 0",
                     enc, addrc, datac, issue_ready);
            miscompares++;
        end
        send_issue(5'd3, 5'd0, 1'b1, 1'b0);
        wait_op_valid();
        vectors++;
        if ({op_a, op_b} !== {32'h11, 32'h0}) begin
            $display("[TB] FAIL simul_operand: got a=%h b=%h required 11 0", op_a, op_b);
            miscompares++;
        end
        release_op();
    endtask

    task automatic test_zero_reg();
        int c0, a0;
        c0 = enc_cnt;
        send_wb(5'd0, 32'hFFFFFFFF);
        #1;
        vectors++;
        if (enc !== 1'b0) begin
            $display("[TB] FAIL r0_write_strobe: got enc=%b required 0", enc);
            miscompares++;
        end
        @(negedge clk);
        @(negedge clk); #1;
        vectors++;
        if (wb_ready !== 1'b1 || enc_cnt != c0) begin
            $display("[TB] FAIL r0_write_dropped: got wb_ready=%b enc_pulses=%0d required 1 0", wb_ready, enc_cnt - c0);
            miscompares++;
        end
        a0 = ena_cnt;
        send_issue(5'd0, 5'd5, 1'b1, 1'b1);
        wait_op_valid();
        vectors++;
        if ({op_a, op_b} !== {32'h0, 32'hDEADBEEF} || ena_cnt != a0) begin
            $display("[TB] FAIL r0_read: got a=%h b=%h ena_pulses=%0d required 0 deadbeef 0", op_a, op_b, ena_cnt - a0);
            miscompares++;
        end
        release_op();
    endtask

    task automatic test_backpressure();
        send_issue(5'd5, 5'd3, 1'b1, 1'b1);
        wait_op_valid();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        vectors++;
        if (wb_ready !== 1'b1) begin
            $display("[TB] FAIL bp_wb_accept: got wb_ready=%b required 1", wb_ready);
            miscompares++;
        end
        @(negedge clk);
        wb_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if ({op_valid, op_a, op_b, wb_ready, enc} !== {1'b1, 32'hDEADBEEF, 32'h11, 1'b0, 1'b0}) begin
                $display("[TB] FAIL bp_hold_%0d: got v=%b a=%h b=%h wb_ready=%b enc=%b required 1 deadbeef 11 0 0",
                         i, op_valid, op_a, op_b, wb_ready, enc);
                miscompares++;
            end
            @(negedge clk);
        end
        release_op();
        #1;
        vectors++;
        if ({op_valid, enc} !== 2'b00) begin
            $display("[TB] FAIL bp_exit: got op_valid=%b enc=%b required 0 0", op_valid, enc);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if ({enc, addrc, datac} !== {1'b1, 5'd7, 32'h22}) begin
            $display("[TB] FAIL bp_deferred_write: got enc=%b addrc=%0d datac=%h required 1 7 22", enc, addrc, datac);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (wb_ready !== 1'b0) begin
            $display("[TB] FAIL bp_wr_hold_ready: got %b required 0", wb_ready);
            miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (wb_ready !== 1'b1) begin
            $display("[TB] FAIL bp_buffer_freed: got %b required 1", wb_ready);
            miscompares++;
        end
        send_issue(5'd7, 5'd0, 1'b1, 1'b0);
        wait_op_valid();
        vectors++;
        if (op_a !== 32'h22) begin
            $display("[TB] FAIL bp_read_r7: got %h required 22", op_a);
            miscompares++;
        end
        release_op();
    endtask

    task automatic test_back_to_back();
        int c0;
        int n = 0;
        c0 = enc_cnt;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        @(negedge clk);
        wb_addr = 5'd10; wb_data = 32'hAA;
        #1;
        vectors++;
        if ({wb_ready, enc, addrc, datac} !== {1'b0, 1'b1, 5'd9, 32'h99}) begin
            $display("[TB] FAIL b2b_full: got wb_ready=%b enc=%b addrc=%0d datac=%h required 0 1 9 99",
                     wb_ready, enc, addrc, datac);
            miscompares++;
        end
        while (wb_ready !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        wb_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (enc_cnt - c0 != 2 || enc_log[c0[5:0]] !== 5'd9 || enc_log[6'(c0 + 1)] !== 5'd10) begin
            $display("[TB] FAIL b2b_order: got %0d writes first=%0d second=%0d required 2 9 10",
                     enc_cnt - c0, enc_log[c0[5:0]], enc_log[6'(c0 + 1)]);
            miscompares++;
        end
        send_issue(5'd9, 5'd10, 1'b1, 1'b1);
        wait_op_valid();
        vectors++;
        if ({op_a, op_b} !== {32'h99, 32'hAA}) begin
            $display("[TB] FAIL b2b_read: got a=%h b=%h required 99 aa", op_a, op_b);
            miscompares++;
        end
        release_op();
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = enc_cnt;
        send_issue(5'd5, 5'd3, 1'b1, 1'b1);
        wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'h77;
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        vectors++;
        if ({wb_ready, op_valid} !== 2'b00) begin
            $display("[TB] FAIL mid_rd_wait: got wb_ready=%b op_valid=%b required 0 0", wb_ready, op_valid);
            miscompares++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({op_valid, ena, enb, enc, wb_ready, issue_ready} !== 6'b000011) begin
            $display("[TB] FAIL mid_reset_state: got %b required 000011",
                     {op_valid, ena, enb, enc, wb_ready, issue_ready});
            miscompares++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (enc_cnt != c0) begin
            $display("[TB] FAIL mid_reset_buffer_discard: got %0d writes required 0", enc_cnt - c0);
            miscompares++;
        end
        send_issue(5'd11, 5'd0, 1'b1, 1'b0);
        wait_op_valid();
        vectors++;
        if (op_a !== 32'hC0DE000B) begin
            $display("[TB] FAIL mid_reset_read_r11: got %h required c0de000b", op_a);
            miscompares++;
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_wb_then_read();
        test_simultaneous();
        test_zero_reg();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
